// File: rtl/scaler_pkg.sv
// Shared constants, divider state type and width helpers for the horizontal scaler control path.
// Pure declarations: no latency or backpressure.
package scaler_pkg;

  localparam int STEP_W       = 16;
  localparam int WIDTH_W      = 13;
  localparam int PIXEL_STEP   = 1024;
  localparam int STEP_MIN     = 256;
  localparam int STEP_MAX     = 16384;
  localparam int STEP_DEFAULT = 1024;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_DONE
  } div_state_t;

  // Numerator width for in_width*PIXEL_STEP + step - 1, with one guard bit.
  function automatic int num_w(input int width_w, input int pixel_step);
    return width_w + $clog2(pixel_step) + 1;
  endfunction

endpackage

// File: rtl/scaler_width_div.sv
// Restoring divider: out_width = ceil(width*PIXEL_STEP/step), saturated; NUM_W+1 cycles from start to done.
// No backpressure: a start in any state restarts with new operands, clr_i drops the result-valid flag.
module scaler_width_div #(
  parameter int STEP_W     = scaler_pkg::STEP_W,
  parameter int WIDTH_W    = scaler_pkg::WIDTH_W,
  parameter int PIXEL_STEP = scaler_pkg::PIXEL_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [WIDTH_W-1:0] width_i,
  input  logic [STEP_W-1:0]  step_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH_W-1:0] quo_o
);
  import scaler_pkg::*;

  localparam int NUM_W = num_w(WIDTH_W, PIXEL_STEP);
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [WIDTH_W-1:0] QMAX = '1;

  div_state_t        state;
  logic [NUM_W-1:0]  num_q;
  logic [NUM_W-1:0]  quo_q;
  logic [STEP_W-1:0] den_q;
  logic [STEP_W-1:0] rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_W-1:0]  num_init;
  logic [STEP_W:0]   rem_sh;
  logic [STEP_W:0]   rem_sub;
  logic              ge;
  logic [WIDTH_W-1:0] quo_sat;

  // Adding step-1 before dividing turns the truncating quotient into a ceiling.
  assign num_init = NUM_W'(width_i) * NUM_W'(PIXEL_STEP) + NUM_W'(step_i) - NUM_W'(1);
  assign rem_sh   = {rem_q, num_q[NUM_W-1]};
  assign rem_sub  = rem_sh - {1'b0, den_q};
  assign ge       = (rem_sh >= {1'b0, den_q});
  assign quo_sat  = (|quo_q[NUM_W-1:WIDTH_W]) ? QMAX : quo_q[WIDTH_W-1:0];
  assign busy_o   = (state != D_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= D_IDLE;
      num_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quo_o  <= '0;
      done_o <= 1'b0;
    end else begin
      if (start_i) begin
        num_q  <= num_init;
        den_q  <= step_i;
        quo_q  <= '0;
        rem_q  <= '0;
        cnt_q  <= '0;
        done_o <= 1'b0;
        state  <= D_RUN;
      end else begin
        case (state)
          D_RUN: begin
            num_q <= num_q << 1;
            quo_q <= {quo_q[NUM_W-2:0], ge};
            rem_q <= ge ? rem_sub[STEP_W-1:0] : rem_sh[STEP_W-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NUM_W - 1)) state <= D_DONE;
          end
          D_DONE: begin
            quo_o  <= quo_sat;
            done_o <= 1'b1;
            state  <= D_IDLE;
          end
          default: state <= D_IDLE;
        endcase
      end
      if (clr_i) done_o <= 1'b0;
    end
  end

endmodule

// File: rtl/scaler_h_ctrl.sv
// Shadows range-checked step writes, applies them at frame start, measures line width and derives output width.
// Step applied 1 cycle after the vs rise; width_vld 26 cycles after the first hs; no backpressure, last write wins.
module scaler_h_ctrl #(
  parameter int PIXEL_STEP   = scaler_pkg::PIXEL_STEP,
  parameter int STEP_W       = scaler_pkg::STEP_W,
  parameter int WIDTH_W      = scaler_pkg::WIDTH_W,
  parameter int STEP_MIN     = scaler_pkg::STEP_MIN,
  parameter int STEP_MAX     = scaler_pkg::STEP_MAX,
  parameter int STEP_DEFAULT = scaler_pkg::STEP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STEP_W-1:0]  cfg_step_i,
  input  logic               cfg_wr_i,
  output logic               cfg_busy_o,
  output logic               cfg_err_o,
  input  logic               vs_i,
  input  logic               hs_i,
  input  logic               de_i,
  output logic [STEP_W-1:0]  scale_step_h,
  output logic               step_upd_o,
  output logic [WIDTH_W-1:0] in_width_o,
  output logic [WIDTH_W-1:0] out_width_o,
  output logic               width_vld_o,
  output logic               line_err_o
);
  import scaler_pkg::*;

  logic [STEP_W-1:0]  shadow_q;
  logic               pending_q;
  logic               vs_q;
  logic               frame_start;
  logic               wr_ok;
  logic [WIDTH_W-1:0] cnt_q;
  logic [WIDTH_W-1:0] cnt_inc;
  logic [WIDTH_W-1:0] line_cnt;
  logic               pix;
  logic               first_seen_q;
  logic               first_q;
  logic               div_start;
  logic               div_busy;
  logic               div_done;

  assign frame_start = vs_i & ~vs_q;
  assign wr_ok       = (cfg_step_i >= STEP_W'(STEP_MIN)) && (cfg_step_i <= STEP_W'(STEP_MAX));
  assign cfg_busy_o  = pending_q;

  // Step shadow: a write on the frame-start cycle lands after the old shadow is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= STEP_W'(STEP_DEFAULT);
      pending_q    <= 1'b0;
      scale_step_h <= STEP_W'(STEP_DEFAULT);
      step_upd_o   <= 1'b0;
      cfg_err_o    <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      vs_q       <= vs_i;
      step_upd_o <= 1'b0;
      if (frame_start && pending_q) begin
        scale_step_h <= shadow_q;
        step_upd_o   <= 1'b1;
        pending_q    <= 1'b0;
      end
      if (cfg_wr_i) begin
        if (wr_ok) begin
          shadow_q  <= cfg_step_i;
          pending_q <= 1'b1;
          cfg_err_o <= 1'b0;
        end else begin
          cfg_err_o <= 1'b1;
        end
      end
    end
  end

  assign pix      = de_i & vs_i;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign line_cnt = pix ? cnt_inc : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      in_width_o   <= '0;
      first_seen_q <= 1'b0;
      first_q      <= 1'b0;
      line_err_o   <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (hs_i) cnt_q <= '0;
      else if (pix) cnt_q <= cnt_inc;
      if (frame_start) begin
        first_seen_q <= 1'b0;
        line_err_o   <= 1'b0;
      end else if (hs_i && (line_cnt != '0)) begin
        if (!first_seen_q) begin
          in_width_o   <= line_cnt;
          first_seen_q <= 1'b1;
          first_q      <= 1'b1;
        end else if (line_cnt != in_width_o) begin
          line_err_o <= 1'b1;
        end
      end
    end
  end

  // Recompute on the first measured line, or when a new step lands and a width is already known.
  assign div_start = first_q | (step_upd_o & (in_width_o != '0));

  scaler_width_div #(
    .STEP_W    (STEP_W),
    .WIDTH_W   (WIDTH_W),
    .PIXEL_STEP(PIXEL_STEP)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start_i(div_start),
    .clr_i  (frame_start),
    .width_i(in_width_o),
    .step_i (scale_step_h),
    .busy_o (div_busy),
    .done_o (div_done),
    .quo_o  (out_width_o)
  );

  assign width_vld_o = div_done & ~div_busy;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Scoreboard bench for scaler_h_ctrl: stimulus pushes expected step updates and width results,
// a negedge monitor pops and compares whenever step_upd_o pulses or width_vld_o rises.
module tb_scaler_h_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_step_i = '0;
  logic        cfg_wr_i = 1'b0;
  logic        cfg_busy_o;
  logic        cfg_err_o;
  logic        vs_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        de_i = 1'b0;
  logic [15:0] scale_step_h;
  logic        step_upd_o;
  logic [12:0] in_width_o;
  logic [12:0] out_width_o;
  logic        width_vld_o;
  logic        line_err_o;

  scaler_h_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_step_i  (cfg_step_i),
    .cfg_wr_i    (cfg_wr_i),
    .cfg_busy_o  (cfg_busy_o),
    .cfg_err_o   (cfg_err_o),
    .vs_i        (vs_i),
    .hs_i        (hs_i),
    .de_i        (de_i),
    .scale_step_h(scale_step_h),
    .step_upd_o  (step_upd_o),
    .in_width_o  (in_width_o),
    .out_width_o (out_width_o),
    .width_vld_o (width_vld_o),
    .line_err_o  (line_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int in_w;
    int out_w;
    int hs_cyc;
  } wexp_t;

  int    step_q[$];
  wexp_t w_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every step_upd pulse and every width_vld rise must match the next queued expectation.
  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    int    es;
    wexp_t ew;
    if (step_upd_o === 1'b1) begin
      if (step_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL step_upd: unexpected pulse, scale_step_h=%0d (cycle %0d)", scale_step_h, cyc);
      end else begin
        es = step_q.pop_front();
        chk("scale_step_h at step_upd", int'(scale_step_h), es);
      end
    end
    if (width_vld_o === 1'b1 && vld_prev == 1'b0) begin
      if (w_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL width_vld: unexpected rise, out_width_o=%0d (cycle %0d)", out_width_o, cyc);
      end else begin
        ew = w_q.pop_front();
        chk("in_width_o at width_vld", int'(in_width_o), ew.in_w);
        chk("out_width_o at width_vld", int'(out_width_o), ew.out_w);
        if (ew.hs_cyc >= 0) chk("width_vld latency", cyc - ew.hs_cyc, 26);
      end
    end
    vld_prev <= (width_vld_o === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int v);
    cfg_step_i = 16'(v);
    cfg_wr_i   = 1'b1;
    tick();
    cfg_wr_i   = 1'b0;
  endtask

  task automatic frame(input bit w, input int v);
    vs_i = 1'b0;
    tick();
    tick();
    vs_i = 1'b1;
    if (w) begin
      cfg_step_i = 16'(v);
      cfg_wr_i   = 1'b1;
    end
    tick();
    cfg_wr_i = 1'b0;
  endtask

  // merge=1 puts the last pixel in the hs cycle itself.
  task automatic line(input int npix, input bit merge, output int hs_cyc);
    de_i = 1'b1;
    repeat (merge ? npix - 1 : npix) tick();
    if (!merge) de_i = 1'b0;
    hs_i   = 1'b1;
    hs_cyc = cyc + 1;
    tick();
    hs_i = 1'b0;
    de_i = 1'b0;
  endtask

  task automatic push_w(input int in_w, input int out_w, input int hs_cyc);
    wexp_t e;
    e.in_w   = in_w;
    e.out_w  = out_w;
    e.hs_cyc = hs_cyc;
    w_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " scale_step_h"}, int'(scale_step_h), 1024);
    chk({tag, " cfg_busy_o"}, int'(cfg_busy_o), 0);
    chk({tag, " cfg_err_o"}, int'(cfg_err_o), 0);
    chk({tag, " step_upd_o"}, int'(step_upd_o), 0);
    chk({tag, " in_width_o"}, int'(in_width_o), 0);
    chk({tag, " out_width_o"}, int'(out_width_o), 0);
    chk({tag, " width_vld_o"}, int'(width_vld_o), 0);
    chk({tag, " line_err_o"}, int'(line_err_o), 0);
  endtask

  initial begin
    int h;
    idle(3);
    rst = 1'b0;
    check_reset_state("reset");

    // Two frames with no writes: step stays at default, no update pulses.
    frame(0, 0);
    idle(20);
    frame(0, 0);
    idle(5);
    chk("idle frames scale_step_h", int'(scale_step_h), 1024);
    chk("idle frames cfg_busy_o", int'(cfg_busy_o), 0);

    // Mid-frame write held until the next frame start.
    idle(3);
    wr(2048);
    chk("pending cfg_busy_o", int'(cfg_busy_o), 1);
    idle(10);
    chk("pending scale_step_h held", int'(scale_step_h), 1024);
    step_q.push_back(2048);
    frame(0, 0);
    chk("applied scale_step_h", int'(scale_step_h), 2048);
    chk("applied cfg_busy_o", int'(cfg_busy_o), 0);

    // Last write wins; a write on the frame-start cycle waits one more frame.
    wr(1536);
    wr(2730);
    step_q.push_back(2730);
    frame(1, 512);
    chk("edge write scale_step_h", int'(scale_step_h), 2730);
    chk("edge write cfg_busy_o", int'(cfg_busy_o), 1);
    idle(5);
    step_q.push_back(512);
    frame(0, 0);
    chk("deferred scale_step_h", int'(scale_step_h), 512);
    chk("deferred cfg_busy_o", int'(cfg_busy_o), 0);

    // Range checks at and beyond both limits.
    wr(100);
    chk("reject 100 cfg_err_o", int'(cfg_err_o), 1);
    chk("reject 100 cfg_busy_o", int'(cfg_busy_o), 0);
    chk("reject 100 scale_step_h", int'(scale_step_h), 512);
    wr(16385);
    chk("reject 16385 cfg_err_o", int'(cfg_err_o), 1);
    wr(255);
    chk("reject 255 cfg_busy_o", int'(cfg_busy_o), 0);
    wr(16384);
    chk("accept 16384 cfg_err_o", int'(cfg_err_o), 0);
    chk("accept 16384 cfg_busy_o", int'(cfg_busy_o), 1);
    wr(2048);
    step_q.push_back(2048);
    frame(0, 0);

    // 600-pixel lines at step 2048.
    idle(4);
    line(600, 0, h);
    push_w(600, 300, h);
    chk("first line in_width_o", int'(in_width_o), 600);
    idle(40);
    line(600, 1, h);
    chk("equal line line_err_o", int'(line_err_o), 0);
    idle(10);

    // New step with a known width recomputes, then the first line recomputes again.
    wr(2730);
    step_q.push_back(2730);
    push_w(600, 226, -1);
    frame(0, 0);
    chk("frame start clears width_vld_o", int'(width_vld_o), 0);
    idle(40);
    line(600, 0, h);
    push_w(600, 226, h);
    idle(40);
    line(599, 0, h);
    chk("short line line_err_o", int'(line_err_o), 1);
    line(600, 0, h);
    chk("sticky line_err_o", int'(line_err_o), 1);

    // Minimum step (4x upscale), then a wide line that saturates the output width.
    wr(256);
    step_q.push_back(256);
    push_w(600, 2400, -1);
    frame(0, 0);
    chk("frame start clears line_err_o", int'(line_err_o), 0);
    idle(40);
    line(3000, 0, h);
    push_w(3000, 8191, h);
    chk("wide line in_width_o", int'(in_width_o), 3000);
    idle(40);

    // Reset in the middle of a division aborts it and the sticky error.
    wr(2048);
    step_q.push_back(2048);
    frame(0, 0);
    idle(5);
    wr(9);
    chk("pre-reset cfg_err_o", int'(cfg_err_o), 1);
    rst  = 1'b1;
    vs_i = 1'b0;
    tick();
    rst = 1'b0;
    check_reset_state("mid-run reset");
    idle(40);
    chk("post-reset width_vld_o", int'(width_vld_o), 0);

    chk("step queue drained", step_q.size(), 0);
    chk("width queue drained", w_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scaler_h_ctrl.md
Name: scaler_h_ctrl

Overview:
Frame-synchronous control block for scaler_h. Accepts scale-step writes from the register side, validates them and shadows them. Applies each new step to scaler_h only at a frame start, so no frame is scaled with two different steps. It also measures the input line width and computes the resulting output width with a sequential divider, for downstream line buffers and status registers.

Parameters:
PIXEL_STEP, 1024, fixed-point unit of scale_step_h (step = H_SCALE*PIXEL_STEP)
STEP_W, 16, width of scale step
WIDTH_W, 13, width of pixel counters (max 8191 px/line)
STEP_MIN, 256, smallest accepted step (4x upscale)
STEP_MAX, 16384, largest accepted step (16x downscale)
STEP_DEFAULT, 1024, step after reset (1:1)

Ports:
clk  in  1  clock, shared with scaler_h
rst  in  1  synchronous reset, active-high
cfg_step_i  in  STEP_W  requested step
cfg_wr_i  in  1  one-cycle write strobe for cfg_step_i
cfg_busy_o  out  1  valid step pending, not yet applied
cfg_err_o  out  1  sticky: a write was rejected as out of range
vs_i  in  1  frame active (high during frame); rising edge = frame start
hs_i  in  1  one-cycle line-boundary pulse
de_i  in  1  input pixel valid
scale_step_h  out  STEP_W  step driven to scaler_h
step_upd_o  out  1  one-cycle pulse when scale_step_h changes
in_width_o  out  WIDTH_W  measured input pixels per line
out_width_o  out  WIDTH_W  ceil(in_width*PIXEL_STEP/step)
width_vld_o  out  1  out_width_o valid for current step and width
line_err_o  out  1  sticky per frame: line width differs from first line

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: scale_step_h=STEP_DEFAULT; all other outputs 0; shadow=STEP_DEFAULT; pending=0; divider FSM in D_IDLE. Reset asserted mid-operation aborts the divider and any pending write.
- Write acceptance:
  - cfg_wr_i with STEP_MIN<=cfg_step_i<=STEP_MAX: shadow<=cfg_step_i, pending=1, cfg_err_o<=0 on the next cycle.
  - Out-of-range write: shadow unchanged, cfg_err_o<=1.
  - Repeated writes while pending: last accepted write wins.
- cfg_busy_o = pending (registered).
- Frame start: vs_i is registered internally; the edge is vs_i & ~vs_q.
  - If pending on the edge cycle: scale_step_h<=shadow, step_upd_o=1 for exactly one cycle, pending<=0.
  - If cfg_wr_i coincides with the edge: the shadow value before the write is applied, and the new write stays pending for the next frame.
  - Frame start also clears line_err_o, width_vld_o and the first-line flag.
- Width measurement:
  - Counter increments on de_i while vs_i=1 and saturates at 2^WIDTH_W-1.
  - On hs_i with count!=0, on the first line of the frame: in_width_o<=count, then start the divider.
  - On later lines: if count!=in_width_o, set line_err_o.
  - On every hs_i, counter<=0. If de_i and hs_i fall in the same cycle, that pixel counts toward the closing line.
- Divider FSM (D_IDLE, D_RUN, D_DONE):
  - Start triggers: first-line latch, or step_upd while in_width_o!=0.
  - On start: width_vld_o<=0; numerator N=in_width*PIXEL_STEP+step-1; NUM_W=WIDTH_W+clog2(PIXEL_STEP)+1.
  - Restoring division, 1 quotient bit per cycle; D_RUN lasts NUM_W cycles.
  - D_DONE: out_width_o<=quotient, saturated to 2^WIDTH_W-1; width_vld_o<=1; return to D_IDLE.
  - A start request while in D_RUN restarts the division with the new operands.
  - Latency: hs_i at cycle T gives in_width_o at T+1 and width_vld_o at T+2+NUM_W (T+26 with defaults).

Decomposition:
- Package scaler_pkg holds:
  - STEP_W, WIDTH_W, PIXEL_STEP defaults
  - STEP_MIN/STEP_MAX/STEP_DEFAULT
  - div_state_t enum
  - function num_w()
- Sub-module scaler_width_div: start/operands in, busy/done/quotient out, abort via restart.
- scaler_h_ctrl keeps the config shadow, edge detect and width counter.

Test Plan:
- Reset, no writes, run 2 frames -> scale_step_h=1024, step_upd_o never asserted, cfg_busy_o=0.
- Write 2048 mid-frame -> cfg_busy_o=1, scale_step_h stays 1024 until next vs_i rise; then 2048, step_upd_o high 1 cycle, cfg_busy_o=0.
- Writes 1536 then 2730 in one frame, plus a write 512 on the exact frame-start cycle -> 2730 applied at that edge, 512 pending and applied at the following frame start.
- Write 100 -> ignored, cfg_err_o=1, scale_step_h unchanged; then write 512 -> cfg_err_o=0, cfg_busy_o=1.
- 600-px lines: step 2048 -> in_width_o=600, out_width_o=300, width_vld_o exactly 26 cycles after first hs_i; step 2730 -> out_width_o=226; step 256 -> 2400.
- One 599-px line in a frame -> line_err_o=1 until next frame start. rst during D_RUN -> all outputs return to reset values the next cycle.
